// File: rtl/unary_stream_decoder.sv
// Purpose : sums the unary product bits of NUM_LANES lanes over one frame into a saturating binary result.
// Latency : result_valid rises the cycle after the terminating ACCUM cycle (lane_done all high, or MAX_CYCLES reached).
// Backpr. : result/overflow/timeout hold in HOLD until result_ready; start is only honoured in IDLE or with result_ready in HOLD.
//
// Ports:
//   clk, reset        - single clock, synchronous active-high reset
//   start             - begin a frame (lanes in the start cycle are not summed)
//   lanes, lane_done  - per-lane unary bit and done level, sampled only in ACCUM
//   result_ready      - downstream consumes the held result
//   busy              - frame is accumulating
//   result_valid      - result holds a completed frame sum
//   result            - running (ACCUM) or final (HOLD) sum
//   overflow          - sticky saturation flag for the current frame
//   timeout           - frame ended by the cycle limit rather than lane_done
module unary_stream_decoder #(
    parameter int NUM_LANES  = 16,
    parameter int ACC_W      = 16,
    parameter int MAX_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_LANES-1:0] lanes,
    input  logic [NUM_LANES-1:0] lane_done,
    input  logic                 result_ready,
    output logic                 busy,
    output logic                 result_valid,
    output logic [ACC_W-1:0]     result,
    output logic                 overflow,
    output logic                 timeout
);

    localparam int PC_W  = $clog2(NUM_LANES + 1);
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               to_q, to_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;

    logic [PC_W-1:0]    pop;
    logic [ACC_W:0]     sum_ext;

    // Population count of the current lane bits.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            pop = pop + PC_W'(lanes[i]);
        end
    end

    // One extra bit catches any carry past the accumulator maximum.
    assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(pop);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        to_d    = to_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    to_d    = 1'b0;
                end
            end
            ACCUM: begin
                if (sum_ext[ACC_W]) begin
                    acc_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    acc_d = sum_ext[ACC_W-1:0];
                end
                cnt_d = cnt_q + 1'b1;
                // lane_done takes precedence when it coincides with the limit cycle.
                if (&lane_done) begin
                    state_d = HOLD;
                    to_d    = 1'b0;
                end else if (cnt_q == LAST_CYC) begin
                    state_d = HOLD;
                    to_d    = 1'b1;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    if (start) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        to_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d == ACCUM);
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result       = acc_q;
    assign overflow     = ovf_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_unary_stream_decoder.sv
module tb_unary_stream_decoder;

    localparam int L  = 4;
    localparam int AW = 4;
    localparam int MC = 8;
    localparam int MAXV = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [L-1:0]  lanes;
    logic [L-1:0]  lane_done;
    logic          result_ready;
    logic          busy;
    logic          result_valid;
    logic [AW-1:0] result;
    logic          overflow;
    logic          timeout;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    unary_stream_decoder #(
        .NUM_LANES (L),
        .ACC_W     (AW),
        .MAX_CYCLES(MC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .lanes       (lanes),
        .lane_done   (lane_done),
        .result_ready(result_ready),
        .busy        (busy),
        .result_valid(result_valid),
        .result      (result),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    typedef struct {
        logic          rst;
        logic          st;
        logic [L-1:0]  ln;
        logic [L-1:0]  dn;
        logic          rr;
        logic          eb;
        logic          ev;
        logic [AW-1:0] er;
        logic          eo;
        logic          et;
        logic          cr;   // compare result (not compared in IDLE)
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic st, input logic [L-1:0] ln,
                       input logic [L-1:0] dn, input logic rr, input logic eb,
                       input logic ev, input int er, input logic eo, input logic et,
                       input logic cr);
        vec_t v;
        v.rst = rst; v.st = st; v.ln = ln; v.dn = dn; v.rr = rr;
        v.eb = eb; v.ev = ev; v.er = AW'(er); v.eo = eo; v.et = et; v.cr = cr;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic st, input logic [L-1:0] ln,
                         input logic [L-1:0] dn, input logic rr);
        reset = rst; start = st; lanes = ln; lane_done = dn; result_ready = rr;
    endtask

    task automatic check(input string name, input int idx, input logic eb, input logic ev,
                         input logic [AW-1:0] er, input logic eo, input logic et,
                         input logic cr);
        logic bad;
        n_vec++;
        bad = (busy !== eb) || (result_valid !== ev) || (overflow !== eo) ||
              (timeout !== et) || (cr && (result !== er));
        if (bad) begin
            n_miss++;
            $display("FAIL %s #%0d: got busy=%b valid=%b result=%0d ovf=%b to=%b, want busy=%b valid=%b result=%0d(chk=%b) ovf=%b to=%b",
                     name, idx, busy, result_valid, result, overflow, timeout,
                     eb, ev, er, cr, eo, et);
        end
    endtask

    // Frame-level reference: phase 0 idle, 1 summing, 2 holding result.
    int m_phase, m_sum, m_cyc;
    bit m_ovf, m_to;

    task automatic model_step(input logic rst, input logic st, input logic [L-1:0] ln,
                              input logic [L-1:0] dn, input logic rr);
        int t;
        if (rst) begin
            m_phase = 0; m_sum = 0; m_cyc = 0; m_ovf = 0; m_to = 0;
        end else if (m_phase == 0 || (m_phase == 2 && rr)) begin
            if (st) begin
                m_phase = 1; m_sum = 0; m_cyc = 0; m_ovf = 0; m_to = 0;
            end else begin
                m_phase = 0;
            end
        end else if (m_phase == 1) begin
            t = m_sum + $countones(ln);
            if (t > MAXV) m_ovf = 1;
            m_sum = (t > MAXV) ? MAXV : t;
            m_cyc++;
            if (dn == {L{1'b1}}) begin
                m_phase = 2; m_to = 0;
            end else if (m_cyc == MC) begin
                m_phase = 2; m_to = 1;
            end
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);

        // reset wins over start and result_ready
        add(1,1,4'hF,4'hF,1, 0,0,0,0,0,1);
        // basic frame: start lanes ignored, 3x1111, then done -> 12
        add(0,1,4'hF,4'h0,0, 1,0,0,0,0,1);
        add(0,0,4'hF,4'h0,0, 1,0,4,0,0,1);
        add(0,0,4'hF,4'h0,0, 1,0,8,0,0,1);
        add(0,0,4'hF,4'h0,0, 1,0,12,0,0,1);
        add(0,0,4'h0,4'hF,0, 0,1,12,0,0,1);
        // backpressure: start/lanes ignored while not ready
        for (int i = 0; i < 5; i++) add(0,1,4'hF,4'hF,0, 0,1,12,0,0,1);
        add(0,0,4'h0,4'h0,1, 0,0,12,0,0,0);
        // saturation at 15, overflow sticky into IDLE
        add(0,1,4'h0,4'h0,0, 1,0,0,0,0,1);
        add(0,0,4'hF,4'h0,0, 1,0,4,0,0,1);
        add(0,0,4'hF,4'h0,0, 1,0,8,0,0,1);
        add(0,0,4'hF,4'h0,0, 1,0,12,0,0,1);
        add(0,0,4'hF,4'h0,0, 1,0,15,1,0,1);
        add(0,0,4'hF,4'h0,0, 1,0,15,1,0,1);
        add(0,0,4'h0,4'hF,0, 0,1,15,1,0,1);
        add(0,0,4'h0,4'h0,1, 0,0,15,1,0,0);
        // timeout after exactly 8 ACCUM cycles
        add(0,1,4'h0,4'h0,0, 1,0,0,0,0,1);
        for (int k = 1; k < MC; k++) add(0,0,4'h1,4'h7,0, 1,0,k,0,0,1);
        add(0,0,4'h1,4'h7,0, 0,1,8,0,1,1);
        // back-to-back: consume and start together
        add(0,1,4'h0,4'h0,1, 1,0,0,0,0,1);
        add(0,0,4'h3,4'h0,0, 1,0,2,0,0,1);
        add(0,0,4'h3,4'h0,0, 1,0,4,0,0,1);
        add(0,0,4'h0,4'hF,0, 0,1,4,0,0,1);
        add(0,0,4'h0,4'h0,1, 0,0,4,0,0,0);
        // done and limit in the same cycle: done wins
        add(0,1,4'h0,4'h0,0, 1,0,0,0,0,1);
        for (int k = 1; k < MC; k++) add(0,0,4'h0,4'h0,0, 1,0,0,0,0,1);
        add(0,0,4'h1,4'hF,0, 0,1,1,0,0,1);
        add(0,0,4'h0,4'h0,1, 0,0,1,0,0,0);
        // reset in the 2nd ACCUM cycle, then activity without start
        add(0,1,4'h0,4'h0,0, 1,0,0,0,0,1);
        add(0,0,4'hF,4'h0,0, 1,0,4,0,0,1);
        add(1,0,4'hF,4'h0,0, 0,0,0,0,0,1);
        add(0,0,4'hF,4'hF,1, 0,0,0,0,0,1);
        add(0,0,4'hF,4'hF,1, 0,0,0,0,0,1);
        // normal frame after reset, then reset in HOLD over start+ready
        add(0,1,4'h0,4'h0,0, 1,0,0,0,0,1);
        add(0,0,4'h1,4'hF,0, 0,1,1,0,0,1);
        add(1,1,4'h0,4'h0,1, 0,0,0,0,0,1);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].st, tbl[i].ln, tbl[i].dn, tbl[i].rr);
            @(posedge clk);
            #1;
            check("table", i, tbl[i].eb, tbl[i].ev, tbl[i].er, tbl[i].eo, tbl[i].et, tbl[i].cr);
        end

        // randomized run against the reference; last table entry left DUT in reset state
        m_phase = 0; m_sum = 0; m_cyc = 0; m_ovf = 0; m_to = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_st, r_rr;
            logic [L-1:0] r_ln, r_dn;
            r_rst = ($urandom_range(0, 99) == 0);
            r_st  = ($urandom_range(0, 2) == 0);
            r_rr  = ($urandom_range(0, 1) == 0);
            r_ln  = L'($urandom);
            r_dn  = ($urandom_range(0, 5) == 0) ? {L{1'b1}} : L'($urandom);
            drive(r_rst, r_st, r_ln, r_dn, r_rr);
            model_step(r_rst, r_st, r_ln, r_dn, r_rr);
            @(posedge clk);
            #1;
            check("random", i, m_phase == 1, m_phase == 2, AW'(m_sum), m_ovf, m_to, m_phase != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
